// File: rtl/us_pkg.sv
// Shared definitions for the ultrasonic transmit path: burst FSM states and default timing.
package us_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_DT1,
    ST_PH2,
    ST_DT2,
    ST_DONE
  } burst_state_t;

  localparam int US_HALF_PERIOD = 400;
  localparam int US_DEAD_TIME   = 12;
  localparam int US_PULSE_NUM   = 16;

endpackage

// File: rtl/burst_gen.sv
// Transmit-burst generator: drives PULSE_NUM complementary, dead-time-separated io1/io2 pulse pairs.
module burst_gen
  import us_pkg::*;
#(
  parameter int HALF_PERIOD = US_HALF_PERIOD,
  parameter int DEAD_TIME   = US_DEAD_TIME,
  parameter int PULSE_NUM   = US_PULSE_NUM
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic       burst_en,
  input  logic       burst_rstn,
  input  logic       tuss_ready,
  output logic       io1,
  output logic       io2,
  output logic       burst_finish,
  output logic       busy,
  output logic [7:0] pulse_cnt,
  output logic       abort_flt
);

  localparam int MAX_T = (HALF_PERIOD > DEAD_TIME) ? HALF_PERIOD : DEAD_TIME;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] DT_LAST = CW'(DEAD_TIME - 1);
  localparam logic [7:0]    PN      = 8'(PULSE_NUM);

  burst_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    pcnt_q, pcnt_d;
  logic          abort_q, abort_d;
  logic          io1_q, io1_d;
  logic          io2_q, io2_d;
  logic          fin_q, fin_d;
  logic          busy_q, busy_d;
  logic          go;

  assign go = burst_en & tuss_ready & burst_rstn;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pcnt_d  = pcnt_q;
    abort_d = abort_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_PH1;
          pcnt_d  = '0;
          abort_d = 1'b0;
        end
      end
      ST_PH1, ST_DT1, ST_PH2, ST_DT2: begin
        // Losing any enable mid-burst aborts immediately; the partial pair count is kept.
        if (!go) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (state_q == ST_PH1 && cnt_q == HP_LAST) begin
          state_d = ST_DT1;
        end else if (state_q == ST_DT1 && cnt_q == DT_LAST) begin
          state_d = ST_PH2;
        end else if (state_q == ST_PH2 && cnt_q == HP_LAST) begin
          state_d = ST_DT2;
        end else if (state_q == ST_DT2 && cnt_q == DT_LAST) begin
          if (pcnt_q < PN) pcnt_d = pcnt_q + 8'd1;
          state_d = (pcnt_q + 8'd1 >= PN) ? ST_DONE : ST_PH1;
        end
      end
      ST_DONE: begin
        if (!burst_en || !burst_rstn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The phase counter only runs while dwelling in a timed state.
    if (state_d == state_q && state_q inside {ST_PH1, ST_DT1, ST_PH2, ST_DT2})
      cnt_d = cnt_q + 1'b1;

    io1_d  = (state_d == ST_PH1);
    io2_d  = (state_d == ST_PH2);
    fin_d  = (state_q == ST_DT2) && (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      abort_q <= 1'b0;
      io1_q   <= 1'b0;
      io2_q   <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      abort_q <= abort_d;
      io1_q   <= io1_d;
      io2_q   <= io2_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
    end
  end

  assign io1          = io1_q;
  assign io2          = io2_q;
  assign burst_finish = fin_q;
  assign busy         = busy_q;
  assign pulse_cnt    = pcnt_q;
  assign abort_flt    = abort_q;

endmodule

// File: tb/tb_burst_gen.sv
// Bench for burst_gen: directed scenarios plus random bursts/aborts against a time-based reference model.
module tb_burst_gen;

  localparam int HP     = 4;
  localparam int DT     = 2;
  localparam int PN     = 3;
  localparam int PERIOD = 2 * (HP + DT);

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic gclk = 1'b0;
  logic rst = 1'b1;
  logic burstEn = 1'b0;
  logic burstRstn = 1'b1;
  logic tussReady = 1'b0;

  logic       io1, io2, burstFinish, busy, abortFlt;
  logic [7:0] pulseCnt;
  logic       defIo1, defIo2, defFinish, defBusy, defAbort;
  logic [7:0] defPcnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: burst position in cycles since the first io1 cycle.
  int         mMode = M_IDLE;
  int         mT = 0;
  logic [7:0] mPcnt = '0;
  logic       mAbort = 1'b0;
  logic       mFinish = 1'b0;

  always #5 gclk = ~gclk;

  burst_gen #(.HALF_PERIOD(HP), .DEAD_TIME(DT), .PULSE_NUM(PN)) dut (
    .gclk(gclk), .rst(rst), .burst_en(burstEn), .burst_rstn(burstRstn),
    .tuss_ready(tussReady), .io1(io1), .io2(io2), .burst_finish(burstFinish),
    .busy(busy), .pulse_cnt(pulseCnt), .abort_flt(abortFlt)
  );

  burst_gen dutDef (
    .gclk(gclk), .rst(rst), .burst_en(burstEn), .burst_rstn(burstRstn),
    .tuss_ready(tussReady), .io1(defIo1), .io2(defIo2), .burst_finish(defFinish),
    .busy(defBusy), .pulse_cnt(defPcnt), .abort_flt(defAbort)
  );

  wire [12:0] obsVec = {io1, io2, burstFinish, busy, pulseCnt, abortFlt};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [12:0] expVec();
    int   p;
    logic e1, e2;
    p  = mT % PERIOD;
    e1 = (mMode == M_RUN) && (p < HP);
    e2 = (mMode == M_RUN) && (p >= HP + DT) && (p < 2 * HP + DT);
    return {e1, e2, mFinish, (mMode != M_IDLE), mPcnt, mAbort};
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic modelStep();
    logic go;
    go = burstEn & tussReady & burstRstn;
    mFinish = 1'b0;
    if (rst) begin
      mMode = M_IDLE; mT = 0; mPcnt = '0; mAbort = 1'b0;
    end else begin
      case (mMode)
        M_IDLE: if (go) begin
          mMode = M_RUN; mT = 0; mPcnt = '0; mAbort = 1'b0;
        end
        M_RUN: if (!go) begin
          mMode = M_IDLE; mAbort = 1'b1;
        end else begin
          mT++;
          mPcnt = 8'(mT / PERIOD);
          if (mT == PN * PERIOD) begin
            mMode = M_DONE; mFinish = 1'b1;
          end
        end
        default: if (!burstEn || !burstRstn) mMode = M_IDLE;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic rstn, input logic rs);
    burstEn = en; tussReady = rdy; burstRstn = rstn; rst = rs;
    @(posedge gclk);
    modelStep();
    #1;
    checkOutput("outs", 32'(obsVec), 32'(expVec()));
  endtask

  // Pin overlap is checked every cycle on both instances.
  always @(negedge gclk) begin
    checkOutput("overlap", 32'(io1 & io2), 32'd0);
    checkOutput("overlapDef", 32'(defIo1 & defIo2), 32'd0);
  end

  initial begin
    int  lat;
    bit  found;
    int  len;
    logic en, rdy, rstn, rs;

    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("rstOuts", 32'(obsVec), 32'd0);
    applyStimulus(0, 1, 1, 0);

    lat = -1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus(1, 1, 1, 0);
      if (i == 0) checkOutput("startIo1", 32'(io1), 32'd1);
      if (burstFinish) begin
        found = 1;
        lat = i;
      end
    end
    checkOutput("finishLat", 32'(lat), 32'd36);
    checkOutput("finalCnt", 32'(pulseCnt), 32'd3);
    applyStimulus(1, 1, 1, 0);
    checkOutput("finishWidth", 32'(burstFinish), 32'd0);
    repeat (19) applyStimulus(1, 1, 1, 0);
    checkOutput("doneBusy", 32'(busy), 32'd1);
    checkOutput("donePins", 32'({io1, io2}), 32'd0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("doneExit", 32'(busy), 32'd0);

    repeat (19) applyStimulus(1, 1, 1, 0);
    checkOutput("inPh2", 32'(io2), 32'd1);
    applyStimulus(1, 0, 1, 0);
    checkOutput("abortPins", 32'({io1, io2}), 32'd0);
    checkOutput("abortFlt", 32'(abortFlt), 32'd1);
    checkOutput("abortCnt", 32'(pulseCnt), 32'd1);
    checkOutput("abortFin", 32'(burstFinish), 32'd0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("restartClr", 32'(abortFlt), 32'd0);
    applyStimulus(0, 1, 1, 0);

    repeat (5) begin
      applyStimulus(1, 1, 0, 0);
      checkOutput("clrNoPins", 32'({io1, io2, busy}), 32'd0);
    end
    applyStimulus(1, 1, 1, 0);
    checkOutput("clrRelease", 32'(io1), 32'd1);

    repeat (4) applyStimulus(1, 1, 1, 0);
    checkOutput("inDt1", 32'({io1, io2, busy}), 32'd1);
    applyStimulus(1, 1, 1, 1);
    checkOutput("midRst", 32'(obsVec), 32'd0);
    applyStimulus(0, 1, 1, 0);

    for (int s = 0; s < 1000; s++) begin
      en   = ($urandom_range(0, 9) != 0);
      rdy  = ($urandom_range(0, 9) != 0);
      rstn = ($urandom_range(0, 9) != 0);
      rs   = ($urandom_range(0, 49) == 0);
      len  = $urandom_range(1, 50);
      for (int c = 0; c < len; c++) applyStimulus(en, rdy, rstn, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
